alu_execute_unit: RTL
=====================

# alu_execute_unit

Execution-stage ALU that consumes the 3-bit ALUControl code produced by the ALU control decoder and performs the selected operation on two operands. Add, sub, and, and or complete in one cycle. Mult and div run as iterative multi-cycle units behind a Start/Busy/Done handshake, so the datapath sequencer can stall while they finish. Results, flags and the high word (product high half or remainder) are registered and held until the next accepted Start.

## Interface
- WIDTH, 16, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- Start  input  1  request; sampled only while Busy=0
- ALUControl  input  3  operation code: 000 add, 001 sub, 010 mult, 011 div, 100 and, 101 or, 11x treated as add
- A  input  WIDTH  operand A (dividend / multiplicand); sampled with accepted Start
- B  input  WIDTH  operand B (divisor / multiplier); sampled with accepted Start
- Result  output  WIDTH  sum/difference/logic result, product low half, or quotient
- ResultHi  output  WIDTH  product high half, or remainder; 0 for other ops
- Carry  output  1  add: carry out; sub: 1 = no borrow (A≥B unsigned); 0 for other ops
- Zero  output  1  Result == 0
- DivByZero  output  1  set when div is issued with B == 0
- Busy  output  1  unit occupied; Start ignored
- Done  output  1  single-cycle pulse; outputs valid from this cycle

## Operation
- States: IDLE, MUL, DIV, DONE. Busy = (state != IDLE).
- IDLE with Start=1: latch ALUControl, A, B.
  - Single-cycle ops, and div with B=0: compute into output registers, go to DONE.
  - Mult: clear accumulator, load iteration counter = WIDTH, go to MUL.
  - Div with B≠0: clear remainder, load counter = WIDTH, go to DIV.
- MUL: unsigned shift-add, one multiplier bit per cycle. The 2·WIDTH product splits into {ResultHi, Result}. After WIDTH iterations, go to DONE.
- DIV: unsigned restoring division, one quotient bit per cycle. Result = quotient, ResultHi = remainder. After WIDTH iterations, go to DONE.
- Div by zero: Result = all ones, ResultHi = A, DivByZero = 1, no iteration.
- DONE: Done = 1 for exactly one cycle, then IDLE. Start during DONE is ignored.
- Add/sub are modulo 2^WIDTH. And/or are bitwise.
- Zero, Carry and DivByZero are computed from the final values and update together with Result.
- Output registers change only in the cycle that enters DONE. They hold their values through IDLE and while the next operation is iterating.
- Operand or ALUControl changes after acceptance have no effect on the operation in flight.

## Timing
- Reset (checked every edge, overrides everything, aborts any in-flight op):
  - state = IDLE
  - Result, ResultHi, Carry, Zero, DivByZero, Busy, Done all = 0
- Start is sampled at edge k while Busy=0.
- Single-cycle op or div-by-zero: Busy=1 and Done=1 in cycle k+1; Busy=0 in cycle k+2.
- Iterative mult/div:
  - Busy=1 in cycles k+1 .. k+WIDTH+1.
  - Done=1 in cycle k+WIDTH+1 (17 cycles after Start for WIDTH=16).
- Maximum issue rate: one op every 2 cycles (single-cycle ops), or every WIDTH+2 cycles (iterative ops).
- Reset asserted on the same edge as Start: reset wins, and the request is lost.

## Configuration
- ALU_EXEC_FAST_MUL_EN defined:
  - Mult uses a combinational WIDTH×WIDTH multiply and follows single-cycle timing (Done at k+1).
  - MUL state and its iteration logic are omitted.
- ALU_EXEC_FAST_MUL_EN undefined: iterative mult as specified above.
- Div is iterative in both builds.

## Test plan
- Add/sub: A=16'hFFFF, B=16'h0001, code 000 -> Done at k+1, Result=0, Carry=1, Zero=1. A=5, B=7, code 001 -> Result=16'hFFFE, Carry=0.
- And/or/illegal:
  - A=16'hF0F0, B=16'h0FF0, code 100 -> Result=16'h00F0.
  - Same operands, code 101 -> Result=16'hFFF0.
  - Code 110, A=3, B=4 -> Result=7.
- Mult: A=16'h1234, B=16'h0100, code 010 -> Busy 17 cycles, Done at k+17, {ResultHi,Result}=32'h00123400. Under ALU_EXEC_FAST_MUL_EN: same values at k+1.
- Div:
  - A=100, B=7, code 011 -> Done at k+17, Result=14, ResultHi=2.
  - A=9, B=0 -> Done at k+1, Result=16'hFFFF, ResultHi=9, DivByZero=1.
- Handshake:
  - Start pulses during MUL, DIV and DONE are ignored.
  - Outputs hold between ops.
  - Changing A/B mid-iteration does not alter the result.
- Reset mid-op: reset in cycle k+5 of a div -> next cycle all outputs 0, Busy=0. A fresh add issued next completes normally.

Source files
------------

// File: rtl/alu_execute_unit.sv
// Execution-stage ALU: single-cycle add/sub/and/or, iterative mult/div behind a Start/Busy/Done handshake.
// Define ALU_EXEC_FAST_MUL_EN to replace the iterative multiplier with a combinational single-cycle multiply.
module alu_execute_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Carry,
  output logic             Zero,
  output logic             DivByZero,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef ALU_EXEC_FAST_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`endif

  state_t               r_state, w_nextState;
  logic [CNT_W-1:0]     r_cnt, w_nextCnt;
  logic [2*WIDTH-1:0]   r_work, w_nextWork;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_result, r_resultHi;
  logic                 r_carry, r_zero, r_divByZero;

  logic                 w_accept, w_load;
  logic [WIDTH-1:0]     w_nResult, w_nHi;
  logic                 w_nCarry, w_nDbz;

  logic [WIDTH:0]       w_addSum, w_subDiff;
  logic [WIDTH:0]       w_divShift, w_divTrial;
  logic [2*WIDTH-1:0]   w_divWork;

  assign w_addSum  = {1'b0, A} + {1'b0, B};
  assign w_subDiff = {1'b0, A} - {1'b0, B};

  // Restoring division step: r_work holds {remainder, dividend/quotient bits}.
  assign w_divShift = r_work[2*WIDTH-1:WIDTH-1];
  assign w_divTrial = w_divShift - {1'b0, r_b};
  assign w_divWork  = w_divTrial[WIDTH] ? {w_divShift[WIDTH-1:0], r_work[WIDTH-2:0], 1'b0}
                                        : {w_divTrial[WIDTH-1:0], r_work[WIDTH-2:0], 1'b1};

`ifdef ALU_EXEC_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fastProd;
  assign w_fastProd = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
`else
  // Shift-add step: r_work holds {partial product high, remaining multiplier bits}.
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH:0]     w_mulSum;
  logic [2*WIDTH-1:0] w_mulWork;
  assign w_mulSum  = {1'b0, r_work[2*WIDTH-1:WIDTH]} + (r_work[0] ? {1'b0, r_a} : '0);
  assign w_mulWork = {w_mulSum, r_work[WIDTH-1:1]};
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextWork  = r_work;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_nResult   = '0;
    w_nHi       = '0;
    w_nCarry    = 1'b0;
    w_nDbz      = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start) begin
          w_accept    = 1'b1;
          w_load      = 1'b1;
          w_nextState = DONE;
          case (ALUControl)
            3'b001: begin
              w_nResult = w_subDiff[WIDTH-1:0];
              w_nCarry  = ~w_subDiff[WIDTH];
            end
            3'b010: begin
`ifdef ALU_EXEC_FAST_MUL_EN
              {w_nHi, w_nResult} = w_fastProd;
`else
              w_load      = 1'b0;
              w_nextState = MUL;
              w_nextWork  = {{WIDTH{1'b0}}, B};
              w_nextCnt   = CNT_W'(WIDTH);
`endif
            end
            3'b011: begin
              if (B == '0) begin
                w_nResult = '1;
                w_nHi     = A;
                w_nDbz    = 1'b1;
              end else begin
                w_load      = 1'b0;
                w_nextState = DIV;
                w_nextWork  = {{WIDTH{1'b0}}, A};
                w_nextCnt   = CNT_W'(WIDTH);
              end
            end
            3'b100: w_nResult = A & B;
            3'b101: w_nResult = A | B;
            default: begin
              w_nResult = w_addSum[WIDTH-1:0];
              w_nCarry  = w_addSum[WIDTH];
            end
          endcase
        end
      end
`ifndef ALU_EXEC_FAST_MUL_EN
      MUL: begin
        w_nextWork = w_mulWork;
        w_nextCnt  = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_nextState        = DONE;
          w_load             = 1'b1;
          {w_nHi, w_nResult} = w_mulWork;
        end
      end
`endif
      DIV: begin
        w_nextWork = w_divWork;
        w_nextCnt  = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_nextState = DONE;
          w_load      = 1'b1;
          w_nResult   = w_divWork[WIDTH-1:0];
          w_nHi       = w_divWork[2*WIDTH-1:WIDTH];
        end
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output registers only move on the cycle that enters DONE, so they hold across later iterations.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_work      <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_resultHi  <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_divByZero <= 1'b0;
`ifndef ALU_EXEC_FAST_MUL_EN
      r_a         <= '0;
`endif
    end else begin
      r_cnt  <= w_nextCnt;
      r_work <= w_nextWork;
      if (w_accept) begin
        r_b <= B;
`ifndef ALU_EXEC_FAST_MUL_EN
        r_a <= A;
`endif
      end
      if (w_load) begin
        r_result    <= w_nResult;
        r_resultHi  <= w_nHi;
        r_carry     <= w_nCarry;
        r_zero      <= (w_nResult == '0);
        r_divByZero <= w_nDbz;
      end
    end
  end

  assign Result    = r_result;
  assign ResultHi  = r_resultHi;
  assign Carry     = r_carry;
  assign Zero      = r_zero;
  assign DivByZero = r_divByZero;
  assign Busy      = (r_state != IDLE);
  assign Done      = (r_state == DONE);

endmodule
